counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl_pkg.sv | 12 +
 rtl/counter_mod_core.sv | 24 ++
 rtl/counter_seq_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the repeat-period counter sequencer.
// Holds the controller state encoding used by the FSM in counter_seq_ctrl.
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/counter_mod_core.sv
// Counting datapath: a WIDTH-bit register with synchronous zero, hold and increment.
// The async clear forces zero at once; zero takes priority over increment.
module counter_mod_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             zero,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (zero) begin
      q <= '0;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Repeat-period counter controller: counts 0..limit for reps+1 periods with pause/abort.
// Owns the FSM, the period counter and the limit/reps captured on an accepted start.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int REPS_W = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [WIDTH-1:0]  limit,
  input  logic [REPS_W-1:0] reps,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              tc,
  output logic              done,
  output logic [REPS_W-1:0] period
);

  state_t              state;
  logic [WIDTH-1:0]    limit_reg;
  logic [REPS_W-1:0]   reps_reg;
  logic                at_limit;
  logic                accept;
  logic                counting;
  logic                core_zero;
  logic                core_inc;

  always_comb begin
    at_limit  = (q == limit_reg);
    accept    = (state == ST_IDLE || state == ST_DONE) && start && !abort;
    tc        = (state == ST_RUN) && !pause && !abort && at_limit;
    // Leaving PAUSE counts as a live cycle, so a pause of N cycles delays the count by N.
    counting  = (state == ST_RUN || state == ST_PAUSE) && !pause && !abort;
    core_zero = abort || accept || tc;
    core_inc  = counting && !at_limit;
  end

  counter_mod_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clear (clear),
    .zero  (core_zero),
    .inc   (core_inc),
    .q     (q)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      limit_reg <= '0;
      reps_reg  <= '0;
      period    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state  <= ST_IDLE;
      period <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            limit_reg <= limit;
            reps_reg  <= reps;
            period    <= '0;
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state <= ST_PAUSE;
          end else if (at_limit) begin
            if (period < reps_reg) begin
              period <= period + REPS_W'(1);
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) state <= ST_RUN;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
